dcache_assoc: RTL and testbench

//  Parametrised N-way set-associative, write-back, write-allocate data cache between CPU and data memory.

---
 rtl/dcache_assoc.sv | 228 ++++++++++++++++++++++
 tb/tb_dcache_assoc.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_assoc.sv
// N-way set-associative, write-back, write-allocate data cache.
// Byte-addressed CPU side, 32-bit block memory side, LRU replacement,
// saturating hit/miss counters.
module dcache_assoc #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INDEX_W = 2,
  parameter int unsigned WAYS    = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                read,
  input  logic                write,
  input  logic [ADDR_W-1:0]   address,
  input  logic [7:0]          writedata,
  output logic [7:0]          readdata,
  output logic                busywait,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-3:0]   mem_address,
  output logic [31:0]         mem_writedata,
  input  logic [31:0]         mem_readdata,
  input  logic                mem_busywait,
  output logic [CNT_W-1:0]    hit_count,
  output logic [CNT_W-1:0]    miss_count
);

  localparam int unsigned SETS  = 2 ** INDEX_W;
  localparam int unsigned TAG_W = ADDR_W - INDEX_W - 2;
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2
  } state_t;

  state_t state;

  // Line storage and metadata
  logic [31:0]      data_q  [SETS][WAYS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [WAY_W-1:0] age_q   [SETS][WAYS];
  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYS-1:0]  dirty_q [SETS];

  logic [WAY_W-1:0] victim_q;
  logic             refilled;

  // Address fields
  logic [1:0]         offset;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic               req;

  assign offset = address[1:0];
  assign index  = address[INDEX_W+1:2];
  assign tag    = address[ADDR_W-1:INDEX_W+2];
  assign req    = read | write;

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [31:0]      hit_word;
  logic [7:0]       hit_byte;
  logic             inv_found;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] old_way;
  logic [WAY_W-1:0] victim;
  logic             victim_dirty;
  logic             wr_hit;
  logic             fill;
  logic             touch_en;
  logic [WAY_W-1:0] touch_way;

  // Tag compare across all ways of the indexed set
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[index][WAY_W'(w)] && (tag_q[index][WAY_W'(w)] == tag)) begin
        hit     = req;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Byte select from the hit line
  always_comb begin
    hit_word = data_q[index][hit_way];
    hit_byte = hit_word[{offset, 3'b000} +: 8];
  end

  // Victim choice: lowest invalid way, otherwise the oldest way
  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    old_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!valid_q[index][WAY_W'(w)] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
      if (age_q[index][WAY_W'(w)] == WAY_W'(WAYS - 1)) begin
        old_way = WAY_W'(w);
      end
    end
    victim       = inv_found ? inv_way : old_way;
    victim_dirty = valid_q[index][victim] & dirty_q[index][victim];
  end

  // Event decode shared by the data and metadata updates
  always_comb begin
    wr_hit    = (state == IDLE) && write && hit;
    fill      = (state == FETCH) && !mem_busywait;
    touch_en  = ((state == IDLE) && hit) || fill;
    touch_way = fill ? victim_q : hit_way;
  end

  // CPU-facing outputs; stall and read data resolve in the request cycle
  always_comb begin
    busywait = 1'b1;
    readdata = '0;
    if (state == IDLE) begin
      busywait = req & ~hit;
      if (read && hit) begin
        readdata = hit_byte;
      end
    end
  end

  // Line data and tags: refill installs a block, write hit patches one byte
  always_ff @(posedge clock) begin
    if (fill) begin
      data_q[index][victim_q] <= mem_readdata;
      tag_q[index][victim_q]  <= tag;
    end else if (wr_hit) begin
      data_q[index][hit_way][{offset, 3'b000} +: 8] <= writedata;
    end
  end

  // Controller: state, metadata, memory request registers and counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      victim_q      <= '0;
      refilled      <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[INDEX_W'(s)] <= '0;
        dirty_q[INDEX_W'(s)] <= '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
          age_q[INDEX_W'(s)][WAY_W'(w)] <= WAY_W'(w);
        end
      end
    end else begin
      if (touch_en) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == touch_way) begin
            age_q[index][WAY_W'(w)] <= '0;
          end else if (age_q[index][WAY_W'(w)] < age_q[index][touch_way]) begin
            age_q[index][WAY_W'(w)] <= WAY_W'(age_q[index][WAY_W'(w)] + 1'b1);
          end
        end
      end

      case (state)
        IDLE: begin
          if (hit) begin
            if (write) begin
              dirty_q[index][hit_way] <= 1'b1;
            end
            if (refilled) begin
              refilled <= 1'b0;
            end else if (hit_count != '1) begin
              hit_count <= hit_count + CNT_W'(1);
            end
          end else if (req) begin
            victim_q <= victim;
            if (miss_count != '1) begin
              miss_count <= miss_count + CNT_W'(1);
            end
            if (victim_dirty) begin
              state         <= WRITEBACK;
              mem_write     <= 1'b1;
              mem_address   <= {tag_q[index][victim], index};
              mem_writedata <= data_q[index][victim];
            end else begin
              state       <= FETCH;
              mem_read    <= 1'b1;
              mem_address <= {tag, index};
            end
          end
        end

        WRITEBACK: begin
          if (!mem_busywait) begin
            state         <= FETCH;
            mem_write     <= 1'b0;
            mem_writedata <= '0;
            mem_read      <= 1'b1;
            mem_address   <= {tag, index};
          end
        end

        FETCH: begin
          if (!mem_busywait) begin
            state                    <= IDLE;
            mem_read                 <= 1'b0;
            mem_address              <= '0;
            valid_q[index][victim_q] <= 1'b1;
            dirty_q[index][victim_q] <= 1'b0;
            refilled                 <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_assoc.sv
// Bench for dcache_assoc: directed vector table against a 5-cycle memory,
// plus reset-during-refill and counter saturation sequences.
module tb_dcache_assoc;

  logic        clock;
  logic        reset;
  logic        read;
  logic        write;
  logic [7:0]  address;
  logic [7:0]  writedata;
  logic [7:0]  readdata;
  logic        busywait;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int n_checks = 0;
  int n_fail   = 0;

  dcache_assoc dut (
    .clock         (clock),
    .reset         (reset),
    .read          (read),
    .write         (write),
    .address       (address),
    .writedata     (writedata),
    .readdata      (readdata),
    .busywait      (busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait),
    .hit_count     (hit_count),
    .miss_count    (miss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: byte at address A initially holds A+0x10; each request
  // takes 5 cycles, completing on the 5th.
  logic [31:0] wmem [64];
  logic [63:0] written = '0;
  int          mcnt    = 0;

  function automatic logic [31:0] init_word(input int unsigned i);
    return {8'(4 * i + 3 + 16), 8'(4 * i + 2 + 16), 8'(4 * i + 1 + 16), 8'(4 * i + 16)};
  endfunction

  assign mem_busywait = (mem_read | mem_write) && (mcnt < 4);
  assign mem_readdata = written[mem_address] ? wmem[mem_address] : init_word(32'(mem_address));

  always @(posedge clock) begin
    if ((mem_read | mem_write) && !mem_busywait) begin
      if (mem_write) begin
        wmem[mem_address]    <= mem_writedata;
        written[mem_address] <= 1'b1;
      end
      mcnt <= 0;
    end else if (mem_read | mem_write) begin
      mcnt <= mcnt + 1;
    end else begin
      mcnt <= 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One CPU access held until busywait drops; records memory traffic seen.
  task automatic do_access(input logic rd, input logic wr, input logic [7:0] a,
                           input logic [7:0] wd, output logic [7:0] rdata,
                           output int stalls, output int mr, output int mw,
                           output logic [5:0] wba, output logic [31:0] wbd,
                           output logic [5:0] fa);
    stalls = 0; mr = 0; mw = 0; wba = '0; wbd = '0; fa = '0;
    @(posedge clock); #1;
    read = rd; write = wr; address = a; writedata = wd;
    @(negedge clock);
    while (busywait && stalls < 100) begin
      if (mem_read) begin
        mr++;
        fa = mem_address;
      end
      if (mem_write) begin
        mw++;
        wba = mem_address;
        wbd = mem_writedata;
      end
      stalls++;
      @(negedge clock);
    end
    rdata = readdata;
    @(posedge clock); #1;
    read = 1'b0; write = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [7:0]  wd;
    logic [7:0]  exp_rdata;
    int          exp_stalls;
    int          exp_mr;
    int          exp_mw;
    logic [5:0]  exp_wba;
    logic [31:0] exp_wbd;
    logic [5:0]  exp_fa;
    int          exp_hits;
    int          exp_misses;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  logic [7:0]  rdata;
  int          stalls, mr, mw;
  logic [5:0]  wba, fa;
  logic [31:0] wbd;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //            rd    wr    addr   wd     rdata  stl mr mw wba    wbd            fa     h  m
    vecs[0]  = '{1'b1, 1'b0, 8'h04, 8'h00, 8'h14,  6, 5, 0, 6'h00, 32'h00000000, 6'h01, 0, 1};
    vecs[1]  = '{1'b1, 1'b0, 8'h05, 8'h00, 8'h15,  0, 0, 0, 6'h00, 32'h00000000, 6'h00, 1, 1};
    vecs[2]  = '{1'b0, 1'b1, 8'h44, 8'h20, 8'h00,  6, 5, 0, 6'h00, 32'h00000000, 6'h11, 1, 2};
    vecs[3]  = '{1'b0, 1'b1, 8'h04, 8'h10, 8'h00,  0, 0, 0, 6'h00, 32'h00000000, 6'h00, 2, 2};
    vecs[4]  = '{1'b1, 1'b0, 8'h84, 8'h00, 8'h94, 11, 5, 5, 6'h11, 32'h57565520, 6'h21, 2, 3};
    vecs[5]  = '{1'b1, 1'b0, 8'h44, 8'h00, 8'h20, 11, 5, 5, 6'h01, 32'h17161510, 6'h11, 2, 4};
    vecs[6]  = '{1'b1, 1'b0, 8'h04, 8'h00, 8'h10,  6, 5, 0, 6'h00, 32'h00000000, 6'h01, 2, 5};
    vecs[7]  = '{1'b1, 1'b0, 8'h47, 8'h00, 8'h57,  0, 0, 0, 6'h00, 32'h00000000, 6'h00, 3, 5};
    vecs[8]  = '{1'b1, 1'b1, 8'h46, 8'hAB, 8'h56,  0, 0, 0, 6'h00, 32'h00000000, 6'h00, 4, 5};
    vecs[9]  = '{1'b1, 1'b0, 8'h46, 8'h00, 8'hAB,  0, 0, 0, 6'h00, 32'h00000000, 6'h00, 5, 5};
    vecs[10] = '{1'b1, 1'b0, 8'h08, 8'h00, 8'h18,  6, 5, 0, 6'h00, 32'h00000000, 6'h02, 5, 6};
    vecs[11] = '{1'b1, 1'b0, 8'h0B, 8'h00, 8'h1B,  0, 0, 0, 6'h00, 32'h00000000, 6'h00, 6, 6};
    vecs[12] = '{1'b1, 1'b0, 8'h84, 8'h00, 8'h94,  6, 5, 0, 6'h00, 32'h00000000, 6'h21, 6, 7};
    vecs[13] = '{1'b1, 1'b0, 8'h04, 8'h00, 8'h10, 11, 5, 5, 6'h11, 32'h57AB5520, 6'h01, 6, 8};

    reset = 1'b0; read = 1'b0; write = 1'b0; address = '0; writedata = '0;

    // Reset state
    #12;
    check("rst busywait", 32'(busywait), 0);
    check("rst readdata", 32'(readdata), 0);
    check("rst mem_read", 32'(mem_read), 0);
    check("rst mem_write", 32'(mem_write), 0);
    check("rst mem_address", 32'(mem_address), 0);
    check("rst mem_writedata", mem_writedata, 0);
    check("rst hit_count", 32'(hit_count), 0);
    check("rst miss_count", 32'(miss_count), 0);
    @(posedge clock); #1;
    reset = 1'b1;

    // Directed vector table
    for (int i = 0; i < NV; i++) begin
      do_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, rdata, stalls, mr, mw, wba, wbd, fa);
      check($sformatf("v%0d readdata", i), 32'(rdata), 32'(vecs[i].exp_rdata));
      check($sformatf("v%0d stall_cycles", i), stalls, vecs[i].exp_stalls);
      check($sformatf("v%0d mem_read_cycles", i), mr, vecs[i].exp_mr);
      check($sformatf("v%0d mem_write_cycles", i), mw, vecs[i].exp_mw);
      if (vecs[i].exp_mw != 0) begin
        check($sformatf("v%0d wb_address", i), 32'(wba), 32'(vecs[i].exp_wba));
        check($sformatf("v%0d wb_data", i), wbd, vecs[i].exp_wbd);
      end
      if (vecs[i].exp_mr != 0) begin
        check($sformatf("v%0d fetch_address", i), 32'(fa), 32'(vecs[i].exp_fa));
      end
      check($sformatf("v%0d hit_count", i), 32'(hit_count), vecs[i].exp_hits);
      check($sformatf("v%0d miss_count", i), 32'(miss_count), vecs[i].exp_misses);
    end

    // Reset asserted in the middle of a refill
    @(posedge clock); #1;
    read = 1'b1; address = 8'hC8;
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    check("midfill mem_read before reset", 32'(mem_read), 1);
    check("midfill mem_address before reset", 32'(mem_address), 32'h32);
    #2;
    reset = 1'b0;
    #1;
    check("midfill mem_read after reset", 32'(mem_read), 0);
    check("midfill mem_address after reset", 32'(mem_address), 0);
    check("midfill busywait after reset", 32'(busywait), 1);
    check("midfill miss_count after reset", 32'(miss_count), 0);
    read = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;

    do_access(1'b1, 1'b0, 8'hC8, 8'h00, rdata, stalls, mr, mw, wba, wbd, fa);
    check("post-reset C8 readdata", 32'(rdata), 32'hD8);
    check("post-reset C8 stall_cycles", stalls, 6);
    check("post-reset C8 mem_write_cycles", mw, 0);
    check("post-reset C8 fetch_address", 32'(fa), 32'h32);
    check("post-reset C8 miss_count", 32'(miss_count), 1);
    do_access(1'b1, 1'b0, 8'h08, 8'h00, rdata, stalls, mr, mw, wba, wbd, fa);
    check("post-reset 08 readdata", 32'(rdata), 32'h18);
    check("post-reset 08 stall_cycles", stalls, 6);
    check("post-reset 08 hit_count", 32'(hit_count), 0);
    check("post-reset 08 miss_count", 32'(miss_count), 2);

    // Hit counter saturation: hold a hitting read for more than 2^16 cycles
    @(posedge clock); #1;
    read = 1'b1; address = 8'hC8;
    repeat (65540) @(posedge clock);
    #1;
    check("sat readdata", 32'(readdata), 32'hD8);
    check("sat busywait", 32'(busywait), 0);
    check("sat hit_count", 32'(hit_count), 32'hFFFF);
    check("sat miss_count", 32'(miss_count), 2);
    read = 1'b0;
    @(posedge clock); #1;
    check("sat hit_count held", 32'(hit_count), 32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
